// File: rtl/instr_fetch_if.sv
// Bus between the X9 fetch stage and its surroundings: ROM word in, control
// and branch-LUT load port in, program counter and run status out.
interface instr_fetch_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int LUT_AW  = 4,
  parameter int CYC_W   = 16
);
  logic               start;
  logic [INSTR_W-1:0] instr_in;
  logic               stall;
  logic               branch_taken;
  logic [LUT_AW-1:0]  branch_idx;
  logic               lut_we;
  logic [LUT_AW-1:0]  lut_waddr;
  logic [PC_W-1:0]    lut_wdata;
  logic [PC_W-1:0]    pc;
  logic               instr_valid;
  logic               done;
  logic               err;
  logic [CYC_W-1:0]   cycles;

  // fetch stage side
  modport master (
    input  start, instr_in, stall, branch_taken, branch_idx,
           lut_we, lut_waddr, lut_wdata,
    output pc, instr_valid, done, err, cycles
  );

  // ROM / control / top-level side
  modport slave (
    output start, instr_in, stall, branch_taken, branch_idx,
           lut_we, lut_waddr, lut_wdata,
    input  pc, instr_valid, done, err, cycles
  );
endinterface

// File: rtl/instr_fetch.sv
// X9 fetch stage: owns the program counter, resolves taken branches through a
// small target LUT, stops on the halt word and counts run cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset; LUT may be loaded, waits for start
// RUN   | fetching; pc advances, holds, or branches every edge
// DONE  | halt seen; done high, LUT may be reloaded, start reruns
module instr_fetch #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter int                 LUT_AW     = 4,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
  parameter int                 CYC_W      = 16
) (
  input logic         clk,
  input logic         reset,
  instr_fetch_if.master bus
);

  localparam int LUT_N = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc_q;
  logic             done_q;
  logic             err_q;
  logic [CYC_W-1:0] cyc_q;
  logic [PC_W-1:0]  lut [LUT_N];

  // carry out of the increment flags the wrap past the top of the ROM
  logic [PC_W:0] pc_inc;
  logic          is_halt;

  assign pc_inc  = {1'b0, pc_q} + (PC_W + 1)'(1);
  assign is_halt = (bus.instr_in == HALT_INSTR);

  // Sequencer, pc, status flags, cycle counter and branch LUT in one process
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pc_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cyc_q  <= '0;
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // LUT is only writable while no fetch can read it
          if (bus.lut_we) lut[bus.lut_waddr] <= bus.lut_wdata;
          if (bus.start) begin
            state  <= S_RUN;
            pc_q   <= '0;
            done_q <= 1'b0;
            cyc_q  <= '0;
          end
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + CYC_W'(1);
          if (!bus.stall) begin
            if (is_halt) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else if (bus.branch_taken) begin
              pc_q <= lut[bus.branch_idx];
            end else begin
              pc_q <= pc_inc[PC_W-1:0];
              if (pc_inc[PC_W]) err_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs; instr_valid must follow stall within the same cycle
  assign bus.pc          = pc_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.cycles      = cyc_q;
  assign bus.instr_valid = (state == S_RUN) && !bus.stall;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized stretch, all
// compared against a cycle-level behavioural model of the fetch stage.
module tb_instr_fetch;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int LUT_AW  = 4;
  localparam int CYC_W   = 16;
  localparam int ROM_N   = 1 << PC_W;
  localparam int CYC_MAX = (1 << CYC_W) - 1;
  localparam logic [INSTR_W-1:0] HALT = 9'h1FF;

  logic clk;
  logic reset;
  logic [INSTR_W-1:0] rom [ROM_N];

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  bit m_run, m_done, m_err;
  int m_pc, m_cyc;
  int m_lut [1 << LUT_AW];

  instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_AW(LUT_AW), .CYC_W(CYC_W)) ifc ();

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_AW(LUT_AW),
                .HALT_INSTR(HALT), .CYC_W(CYC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  assign ifc.instr_in = rom[ifc.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},          32'(ifc.pc),          32'(m_pc));
    chk({tag, ".done"},        32'(ifc.done),        32'(m_done));
    chk({tag, ".err"},         32'(ifc.err),         32'(m_err));
    chk({tag, ".cycles"},      32'(ifc.cycles),      32'(m_cyc));
    chk({tag, ".instr_valid"}, 32'(ifc.instr_valid), 32'(m_run && !ifc.stall));
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err = 0; m_pc = 0; m_cyc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  // what one rising edge does, given the inputs currently applied
  task automatic model_edge();
    if (m_run) begin
      m_cyc = (m_cyc < CYC_MAX) ? m_cyc + 1 : CYC_MAX;
      if (ifc.stall) begin
      end else if (rom[m_pc] == HALT) begin
        m_run = 0; m_done = 1;
      end else if (ifc.branch_taken) begin
        m_pc = m_lut[ifc.branch_idx];
      end else begin
        m_pc = m_pc + 1;
        if (m_pc == ROM_N) begin m_pc = 0; m_err = 1; end
      end
    end else begin
      if (ifc.lut_we) m_lut[ifc.lut_waddr] = int'(ifc.lut_wdata);
      if (ifc.start) begin m_run = 1; m_pc = 0; m_done = 0; m_cyc = 0; end
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clr_inputs();
    ifc.start = 0; ifc.stall = 0; ifc.branch_taken = 0; ifc.branch_idx = '0;
    ifc.lut_we = 0; ifc.lut_waddr = '0; ifc.lut_wdata = '0;
  endtask

  task automatic fill_rom_plain();
    foreach (rom[i]) rom[i] = INSTR_W'($urandom_range(0, 510));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1;
    model_reset();
    #1;
    check_all(tag);
    clr_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic pulse_start(input string tag);
    ifc.start = 1;
    tick(tag);
    ifc.start = 0;
  endtask

  task automatic lut_write(input int addr, input int data, input string tag);
    ifc.lut_we = 1; ifc.lut_waddr = LUT_AW'(addr); ifc.lut_wdata = PC_W'(data);
    tick(tag);
    ifc.lut_we = 0;
  endtask

  task automatic run_until_done(input int limit, input string tag);
    for (int i = 0; i < limit && !m_done; i++) tick(tag);
    chk({tag, ".reached_done"}, 32'(ifc.done), 32'd1);
  endtask

  initial begin
    int cyc_base;
    reset = 1;
    clr_inputs();
    fill_rom_plain();
    model_reset();

    // reset state
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 0;
    tick("idle");

    // straight line to a halt at pc 5
    rom[5] = HALT;
    pulse_start("sl_start");
    chk("sl_first_pc", 32'(ifc.pc), 32'd0);
    chk("sl_first_valid", 32'(ifc.instr_valid), 32'd1);
    for (int i = 0; i < 6; i++) tick("sl_run");
    chk("sl_done", 32'(ifc.done), 32'd1);
    chk("sl_pc", 32'(ifc.pc), 32'd5);
    chk("sl_cycles", 32'(ifc.cycles), 32'd6);
    chk("sl_err", 32'(ifc.err), 32'd0);
    tick("sl_done_hold");

    // branch through lut[3]
    rom[5]  = 9'h000;
    rom[45] = HALT;
    lut_write(3, 40, "br_lut_wr");
    pulse_start("br_start");
    tick("br_pc1");
    tick("br_pc2");
    ifc.branch_taken = 1; ifc.branch_idx = 4'd3;
    tick("br_take");
    ifc.branch_taken = 0;
    chk("br_target", 32'(ifc.pc), 32'd40);
    tick("br_next");
    chk("br_after", 32'(ifc.pc), 32'd41);
    lut_write(3, 99, "br_lut_wr_in_run");
    run_until_done(20, "br_halt");

    // the write issued during RUN must not have landed
    pulse_start("br2_start");
    ifc.branch_taken = 1; ifc.branch_idx = 4'd3;
    tick("br2_take");
    ifc.branch_taken = 0;
    chk("br_lut_unchanged", 32'(ifc.pc), 32'd40);
    run_until_done(20, "br2_halt");

    // stall at pc 4, then halt with a simultaneous branch at pc 6
    rom[6] = HALT;
    pulse_start("st_start");
    for (int i = 0; i < 4; i++) tick("st_to4");
    cyc_base = m_cyc;
    ifc.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick("st_hold");
      chk("st_valid_low", 32'(ifc.instr_valid), 32'd0);
    end
    chk("st_pc_held", 32'(ifc.pc), 32'd4);
    chk("st_cycles_adv", 32'(ifc.cycles), 32'(cyc_base + 3));
    ifc.stall = 0;
    tick("st_pc5");
    tick("st_pc6");
    ifc.branch_taken = 1; ifc.branch_idx = 4'd3;
    tick("pri_halt_branch");
    ifc.branch_taken = 0;
    chk("pri_done", 32'(ifc.done), 32'd1);
    chk("pri_pc", 32'(ifc.pc), 32'd6);
    rom[6] = 9'h000;

    // randomized stretch
    foreach (rom[i]) rom[i] = ($urandom_range(0, 15) == 0) ? HALT : INSTR_W'($urandom_range(0, 510));
    for (int i = 0; i < 800; i++) begin
      ifc.start        = ($urandom_range(0, 9) == 0);
      ifc.stall        = ($urandom_range(0, 3) == 0);
      ifc.branch_taken = ($urandom_range(0, 4) == 0);
      ifc.branch_idx   = LUT_AW'($urandom_range(0, 15));
      ifc.lut_we       = ($urandom_range(0, 5) == 0);
      ifc.lut_waddr    = LUT_AW'($urandom_range(0, 15));
      ifc.lut_wdata    = PC_W'($urandom_range(0, ROM_N - 1));
      tick("rnd");
    end
    clr_inputs();

    // async reset between edges in the middle of a run
    fill_rom_plain();
    do_reset("pre_rst");
    lut_write(3, 40, "rst_lut_wr");
    pulse_start("rst_start");
    for (int i = 0; i < 7; i++) tick("rst_to7");
    chk("rst_at7", 32'(ifc.pc), 32'd7);
    #3;
    reset = 1;
    model_reset();
    #1;
    chk("rst_async_pc", 32'(ifc.pc), 32'd0);
    chk("rst_async_cycles", 32'(ifc.cycles), 32'd0);
    chk("rst_async_valid", 32'(ifc.instr_valid), 32'd0);
    check_all("rst_async");
    @(negedge clk);
    reset = 0;
    pulse_start("rst_restart");
    ifc.branch_taken = 1; ifc.branch_idx = 4'd3;
    tick("rst_lut_cleared");
    ifc.branch_taken = 0;
    chk("rst_lut3_zero", 32'(ifc.pc), 32'd0);

    // wrap-around past the top of the ROM
    do_reset("pre_wrap");
    pulse_start("wrap_start");
    for (int i = 0; i < ROM_N; i++) tick("wrap_run");
    chk("wrap_pc", 32'(ifc.pc), 32'd0);
    chk("wrap_err", 32'(ifc.err), 32'd1);
    rom[2] = HALT;
    run_until_done(10, "wrap_halt");
    pulse_start("wrap_restart");
    chk("wrap_err_sticky", 32'(ifc.err), 32'd1);
    tick("wrap_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
